// File: rtl/hazard_detection_unit.sv
// rtl/hazard_detection_unit.sv - load-use, divide-occupancy and redirect hazard controller
// Combinational stall/flush controls from a small divide FSM plus saturating event counters.
module hazard_detection_unit #(
  parameter int DIV_CYCLES = 8,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [4:0]           ID_ADDR1,
  input  logic [4:0]           ID_ADDR2,
  input  logic                 ID_USES1,
  input  logic                 ID_USES2,
  input  logic [4:0]           EXE_ADDR,
  input  logic                 EXE_MEMREAD,
  input  logic                 EXE_REGWRITE,
  input  logic                 EXE_DIV,
  input  logic                 BRANCH_TAKEN,
  output logic                 PC_STALL,
  output logic                 IF_ID_STALL,
  output logic                 IF_ID_FLUSH,
  output logic                 ID_EX_STALL,
  output logic                 ID_EX_BUBBLE,
  output logic                 EX_MEM_BUBBLE,
  output logic                 DIV_BUSY,
  output logic [CNT_WIDTH-1:0] STALL_COUNT,
  output logic [CNT_WIDTH-1:0] FLUSH_COUNT
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_DIV_RUN  = 2'b01,
    ST_DIV_DONE = 2'b10
  } state_t;

  // The entry cycle is already one stall, so the run phase counts DIV_CYCLES-1 more.
  localparam logic [7:0]           DCNT_LOAD = 8'(DIV_CYCLES - 2);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};

  state_t               r_state;
  state_t               w_next_state;
  logic [7:0]           r_dcnt;
  logic [7:0]           w_next_dcnt;
  logic [CNT_WIDTH-1:0] r_stall_count;
  logic [CNT_WIDTH-1:0] r_flush_count;
  logic                 w_hit1;
  logic                 w_hit2;
  logic                 w_lu;

  assign w_hit1 = ID_USES1 && (ID_ADDR1 == EXE_ADDR);
  assign w_hit2 = ID_USES2 && (ID_ADDR2 == EXE_ADDR);
  assign w_lu   = EXE_MEMREAD && EXE_REGWRITE && (EXE_ADDR != 5'd0) && (w_hit1 || w_hit2);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= ST_IDLE;
      r_dcnt  <= 8'd0;
    end else begin
      r_state <= w_next_state;
      r_dcnt  <= w_next_dcnt;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_dcnt  = r_dcnt;
    case (r_state)
      ST_IDLE: begin
        if (!BRANCH_TAKEN && EXE_DIV) begin
          w_next_state = ST_DIV_RUN;
          w_next_dcnt  = DCNT_LOAD;
        end
      end
      ST_DIV_RUN: begin
        if (r_dcnt == 8'd0) begin
          w_next_state = ST_DIV_DONE;
        end else begin
          w_next_dcnt = r_dcnt - 8'd1;
        end
      end
      ST_DIV_DONE: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
        w_next_dcnt  = 8'd0;
      end
    endcase
  end

  always_comb begin
    PC_STALL      = 1'b0;
    IF_ID_STALL   = 1'b0;
    IF_ID_FLUSH   = 1'b0;
    ID_EX_STALL   = 1'b0;
    ID_EX_BUBBLE  = 1'b0;
    EX_MEM_BUBBLE = 1'b0;
    DIV_BUSY      = 1'b0;
    if (!RESET) begin
      case (r_state)
        ST_IDLE: begin
          if (BRANCH_TAKEN) begin
            IF_ID_FLUSH  = 1'b1;
            ID_EX_BUBBLE = 1'b1;
          end else if (EXE_DIV) begin
            PC_STALL      = 1'b1;
            IF_ID_STALL   = 1'b1;
            ID_EX_STALL   = 1'b1;
            EX_MEM_BUBBLE = 1'b1;
            DIV_BUSY      = 1'b1;
          end else if (w_lu) begin
            PC_STALL     = 1'b1;
            IF_ID_STALL  = 1'b1;
            ID_EX_BUBBLE = 1'b1;
          end
        end
        ST_DIV_RUN: begin
          PC_STALL      = 1'b1;
          IF_ID_STALL   = 1'b1;
          ID_EX_STALL   = 1'b1;
          EX_MEM_BUBBLE = 1'b1;
          DIV_BUSY      = 1'b1;
        end
        default: begin
          PC_STALL = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else begin
      if (PC_STALL && (r_stall_count != CNT_MAX)) begin
        r_stall_count <= r_stall_count + CNT_ONE;
      end
      if (IF_ID_FLUSH && (r_flush_count != CNT_MAX)) begin
        r_flush_count <= r_flush_count + CNT_ONE;
      end
    end
  end

  assign STALL_COUNT = r_stall_count;
  assign FLUSH_COUNT = r_flush_count;

endmodule

// File: tb/tb_hazard_detection_unit.sv
// tb/tb_hazard_detection_unit.sv - vector table plus divide/reset/saturation sequences
module tb_hazard_detection_unit;

  localparam logic [6:0] C_NONE = 7'b0000000;
  localparam logic [6:0] C_LU   = 7'b1100100;
  localparam logic [6:0] C_BR   = 7'b0010100;
  localparam logic [6:0] C_DIV  = 7'b1101011;

  logic        clk;
  logic        reset;
  logic [4:0]  id_addr1, id_addr2, exe_addr;
  logic        id_uses1, id_uses2, exe_memread, exe_regwrite, exe_div, branch_taken;
  logic        pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_bubble, ex_mem_bubble, div_busy;
  logic [31:0] stall_count, flush_count;
  logic        s_pc_stall, s_if_id_stall, s_if_id_flush, s_id_ex_stall, s_id_ex_bubble;
  logic        s_ex_mem_bubble, s_div_busy;
  logic [3:0]  s_stall_count, s_flush_count;

  hazard_detection_unit #(.DIV_CYCLES(8), .CNT_WIDTH(32)) u_dut (
    .CLK(clk), .RESET(reset),
    .ID_ADDR1(id_addr1), .ID_ADDR2(id_addr2), .ID_USES1(id_uses1), .ID_USES2(id_uses2),
    .EXE_ADDR(exe_addr), .EXE_MEMREAD(exe_memread), .EXE_REGWRITE(exe_regwrite),
    .EXE_DIV(exe_div), .BRANCH_TAKEN(branch_taken),
    .PC_STALL(pc_stall), .IF_ID_STALL(if_id_stall), .IF_ID_FLUSH(if_id_flush),
    .ID_EX_STALL(id_ex_stall), .ID_EX_BUBBLE(id_ex_bubble), .EX_MEM_BUBBLE(ex_mem_bubble),
    .DIV_BUSY(div_busy), .STALL_COUNT(stall_count), .FLUSH_COUNT(flush_count)
  );

  hazard_detection_unit #(.DIV_CYCLES(8), .CNT_WIDTH(4)) u_sat (
    .CLK(clk), .RESET(reset),
    .ID_ADDR1(id_addr1), .ID_ADDR2(id_addr2), .ID_USES1(id_uses1), .ID_USES2(id_uses2),
    .EXE_ADDR(exe_addr), .EXE_MEMREAD(exe_memread), .EXE_REGWRITE(exe_regwrite),
    .EXE_DIV(exe_div), .BRANCH_TAKEN(branch_taken),
    .PC_STALL(s_pc_stall), .IF_ID_STALL(s_if_id_stall), .IF_ID_FLUSH(s_if_id_flush),
    .ID_EX_STALL(s_id_ex_stall), .ID_EX_BUBBLE(s_id_ex_bubble), .EX_MEM_BUBBLE(s_ex_mem_bubble),
    .DIV_BUSY(s_div_busy), .STALL_COUNT(s_stall_count), .FLUSH_COUNT(s_flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [4:0] a1, a2, ea;
    logic       u1, u2, mr, rw, br;
    logic [6:0] exp;
  } vec_t;

  typedef struct {
    string       name;
    logic [6:0]  ctl;
    logic [31:0] stall;
    logic [31:0] flush;
    logic [3:0]  sat;
  } exp_t;

  vec_t        vt[10];
  exp_t        sb_q[$];
  int          n_vec  = 0;
  int          n_miss = 0;
  logic [31:0] m_stall, m_flush;
  logic [3:0]  m_sat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_in();
    id_addr1 = 5'd0; id_addr2 = 5'd0; exe_addr = 5'd0;
    id_uses1 = 1'b0; id_uses2 = 1'b0; exe_memread = 1'b0; exe_regwrite = 1'b0;
    exe_div = 1'b0; branch_taken = 1'b0;
  endtask

  task automatic set_vec(input vec_t v);
    id_addr1 = v.a1; id_addr2 = v.a2; exe_addr = v.ea;
    id_uses1 = v.u1; id_uses2 = v.u2; exe_memread = v.mr; exe_regwrite = v.rw;
    branch_taken = v.br;
  endtask

  // Drive is already applied; push expectation, compare at negedge, then advance the model.
  task automatic cycle(input string name, input logic [6:0] exp_ctl);
    exp_t e;
    logic [6:0] act;
    e.name = name; e.ctl = exp_ctl; e.stall = m_stall; e.flush = m_flush; e.sat = m_sat;
    sb_q.push_back(e);
    @(negedge clk);
    if (sb_q.size() == 0) begin
      n_vec++; n_miss++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb_q.pop_front();
      act = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_bubble, ex_mem_bubble, div_busy};
      chk({e.name, ".ctl"}, {25'd0, act}, {25'd0, e.ctl});
      chk({e.name, ".stall_cnt"}, stall_count, e.stall);
      chk({e.name, ".flush_cnt"}, flush_count, e.flush);
      chk({e.name, ".sat_cnt"}, {28'd0, s_stall_count}, {28'd0, e.sat});
    end
    @(posedge clk);
    if (reset) begin
      m_stall = 32'd0; m_flush = 32'd0; m_sat = 4'd0;
    end else begin
      if (exp_ctl[6]) begin
        m_stall = m_stall + 32'd1;
        if (m_sat != 4'hf) m_sat = m_sat + 4'd1;
      end
      if (exp_ctl[4]) m_flush = m_flush + 32'd1;
    end
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //           name        a1     a2     ea     u1 u2 mr rw br exp
    vt[0] = '{"lu_rs1",     5'd5,  5'd7,  5'd5,  1, 1, 1, 1, 0, C_LU};
    vt[1] = '{"lw_x0",      5'd0,  5'd0,  5'd0,  1, 1, 1, 1, 0, C_NONE};
    vt[2] = '{"rs2_unused", 5'd3,  5'd5,  5'd5,  1, 0, 1, 1, 0, C_NONE};
    vt[3] = '{"lu_rs2",     5'd3,  5'd5,  5'd5,  1, 1, 1, 1, 0, C_LU};
    vt[4] = '{"no_regwr",   5'd5,  5'd5,  5'd5,  1, 1, 1, 0, 0, C_NONE};
    vt[5] = '{"not_load",   5'd5,  5'd5,  5'd5,  1, 1, 0, 1, 0, C_NONE};
    vt[6] = '{"br_over_lu", 5'd5,  5'd7,  5'd5,  1, 1, 1, 1, 1, C_BR};
    vt[7] = '{"br_only",    5'd1,  5'd2,  5'd9,  1, 1, 0, 0, 1, C_BR};
    vt[8] = '{"addr_miss",  5'd5,  5'd6,  5'd7,  1, 1, 1, 1, 0, C_NONE};
    vt[9] = '{"lu_x31",     5'd31, 5'd0,  5'd31, 1, 0, 1, 1, 0, C_LU};

    clear_in();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    m_stall = 32'd0; m_flush = 32'd0; m_sat = 4'd0;

    set_vec(vt[0]);
    cycle("reset_hold_lu", C_NONE);
    reset = 1'b0;
    clear_in();
    cycle("after_reset", C_NONE);

    for (int i = 0; i < 10; i++) begin
      set_vec(vt[i]);
      cycle(vt[i].name, vt[i].exp);
    end
    clear_in();
    cycle("idle", C_NONE);

    // Two back-to-back divides from a cleared counter; LU and branch must be ignored mid-run.
    reset = 1'b1;
    cycle("reset_pulse", C_NONE);
    reset = 1'b0;
    exe_div = 1'b1;
    for (int i = 0; i < 8; i++) cycle($sformatf("div1_%0d", i), C_DIV);
    cycle("div1_done", C_NONE);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        set_vec(vt[6]);
      end else begin
        set_vec(vt[8]);
        branch_taken = 1'b0;
      end
      cycle($sformatf("div2_%0d", i), C_DIV);
    end
    clear_in();
    branch_taken = 1'b1;
    cycle("div2_done_br", C_NONE);
    chk("stall16", stall_count, 32'd16);
    branch_taken = 1'b0;
    cycle("post_div", C_NONE);

    // Reset on the fourth DIV_RUN cycle, then a fresh full-length divide.
    exe_div = 1'b1;
    cycle("rdiv_entry", C_DIV);
    for (int i = 0; i < 3; i++) cycle($sformatf("rdiv_run%0d", i), C_DIV);
    reset = 1'b1;
    cycle("rdiv_reset", C_NONE);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) cycle($sformatf("div3_%0d", i), C_DIV);
    exe_div = 1'b0;
    cycle("div3_done", C_NONE);
    cycle("div3_idle", C_NONE);
    chk("stall8_after_reset", stall_count, 32'd8);

    // Saturation on the 4-bit instance.
    set_vec(vt[0]);
    for (int i = 0; i < 20; i++) cycle($sformatf("sat_%0d", i), C_LU);
    clear_in();
    cycle("sat_end", C_NONE);
    chk("sat_hold15", {28'd0, s_stall_count}, 32'd15);
    chk("main_no_sat", stall_count, 32'd28);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
